// File: rtl/li_seq_gen.sv
// li_seq_gen: expands a "load 32-bit constant into rd" request into the
// shortest RV32I LUI/ADDI sequence and streams it out over valid/ready.
// One request is in flight at a time; a new request is taken only in IDLE.
module li_seq_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_value,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic        inst_last,
    output logic        busy,
    output logic [15:0] emit_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_LUI  = 2'd1,
        EMIT_ADDI = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // LUI rd, imm20
    function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    // ADDI rd, rs1, imm12
    function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                             input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  rd_r, rd_s;
    logic [11:0] lo_r, lo_s;
    logic        inst_valid_r, inst_valid_s;
    logic [31:0] inst_out_r, inst_out_s;
    logic        inst_last_r, inst_last_s;
    logic [15:0] emit_cnt_r;
    logic [19:0] hi_s;
    logic        handshake_s;

    // (value + 0x800) >> 12 with the carry out of bit 31 discarded: adding
    // 0x800 only reaches bit 12 through bit 11, so it is the upper 20 bits
    // plus bit 11, taken modulo 2^20. This pre-compensates the sign
    // extension that ADDI applies to the low 12 bits.
    assign hi_s        = req_value[31:12] + {19'd0, req_value[11]};
    assign handshake_s = inst_valid_r && inst_ready;

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so that they leave the block straight from flops.
    always_comb begin
        state_s      = state_r;
        rd_s         = rd_r;
        lo_s         = lo_r;
        inst_valid_s = inst_valid_r;
        inst_out_s   = inst_out_r;
        inst_last_s  = inst_last_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    rd_s         = req_rd;
                    lo_s         = req_value[11:0];
                    inst_valid_s = 1'b1;
                    if (req_rd == 5'd0) begin
                        // Writes to x0 are discarded: a single canonical NOP.
                        state_s     = EMIT_ADDI;
                        inst_out_s  = NOP_INST;
                        inst_last_s = 1'b1;
                    end else if (hi_s != 20'd0) begin
                        // Upper part needed; ADDI follows only if lo is non-zero.
                        state_s     = EMIT_LUI;
                        inst_out_s  = enc_lui(hi_s, req_rd);
                        inst_last_s = (req_value[11:0] == 12'd0);
                    end else begin
                        // Value fits a sign-extended 12-bit immediate.
                        state_s     = EMIT_ADDI;
                        inst_out_s  = enc_addi(req_value[11:0], 5'd0, req_rd);
                        inst_last_s = 1'b1;
                    end
                end else begin
                    inst_valid_s = 1'b0;
                    inst_out_s   = 32'd0;
                    inst_last_s  = 1'b0;
                end
            end
            EMIT_LUI: begin
                if (handshake_s) begin
                    if (inst_last_r) begin
                        state_s      = IDLE;
                        inst_valid_s = 1'b0;
                        inst_out_s   = 32'd0;
                        inst_last_s  = 1'b0;
                    end else begin
                        // Back-to-back ADDI that adds the low part onto rd.
                        state_s     = EMIT_ADDI;
                        inst_out_s  = enc_addi(lo_r, rd_r, rd_r);
                        inst_last_s = 1'b1;
                    end
                end else begin
                    state_s = EMIT_LUI;
                end
            end
            EMIT_ADDI: begin
                if (handshake_s) begin
                    state_s      = IDLE;
                    inst_valid_s = 1'b0;
                    inst_out_s   = 32'd0;
                    inst_last_s  = 1'b0;
                end else begin
                    state_s = EMIT_ADDI;
                end
            end
            default: begin
                state_s      = IDLE;
                inst_valid_s = 1'b0;
                inst_out_s   = 32'd0;
                inst_last_s  = 1'b0;
            end
        endcase
    end

    // State, captured request fields and registered instruction outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            rd_r         <= 5'd0;
            lo_r         <= 12'd0;
            inst_valid_r <= 1'b0;
            inst_out_r   <= 32'd0;
            inst_last_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            rd_r         <= rd_s;
            lo_r         <= lo_s;
            inst_valid_r <= inst_valid_s;
            inst_out_r   <= inst_out_s;
            inst_last_r  <= inst_last_s;
        end
    end

    // Free-running count of instruction handshakes, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_cnt_r <= 16'd0;
        end else if (handshake_s) begin
            emit_cnt_r <= emit_cnt_r + 16'd1;
        end else begin
            emit_cnt_r <= emit_cnt_r;
        end
    end

    assign req_ready  = (state_r == IDLE);
    assign busy       = (state_r != IDLE);
    assign inst_valid = inst_valid_r;
    assign inst_out   = inst_out_r;
    assign inst_last  = inst_last_r;
    assign emit_cnt   = emit_cnt_r;

endmodule

// File: tb/tb_li_seq_gen.sv
// Testbench for li_seq_gen: directed cases plus randomized requests and
// backpressure, checked against a reference that derives the instruction
// list from the load-immediate rules with plain arithmetic.
module tb_li_seq_gen;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [31:0] req_value;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic        inst_last;
    logic        busy;
    logic [15:0] emit_cnt;

    int          n_checks;
    int          n_fail;
    logic [15:0] cnt_exp;
    logic [31:0] exp_inst_q[$];
    logic        exp_last_q[$];

    li_seq_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_value  (req_value),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_last  (inst_last),
        .busy       (busy),
        .emit_cnt   (emit_cnt)
    );

    // 10 ns clock; rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the instruction list that materialises val into x[rd].
    task automatic model_push(input int rd, input logic [31:0] val);
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] rd32;
        hi   = (val + 32'h0000_0800) >> 12;
        lo   = val & 32'h0000_0FFF;
        rd32 = rd;
        if (rd == 0) begin
            exp_inst_q.push_back(32'h0000_0013);
            exp_last_q.push_back(1'b1);
        end else if (hi != 32'd0) begin
            exp_inst_q.push_back((hi << 12) | (rd32 << 7) | 32'h37);
            exp_last_q.push_back(lo == 32'd0);
            if (lo != 32'd0) begin
                exp_inst_q.push_back((lo << 20) | (rd32 << 15) | (rd32 << 7) | 32'h13);
                exp_last_q.push_back(1'b1);
            end
        end else begin
            exp_inst_q.push_back((lo << 20) | (rd32 << 7) | 32'h13);
            exp_last_q.push_back(1'b1);
        end
    endtask

    // One request, entered and left at a falling edge.
    // mode 0: always ready, 1: 3 stall cycles per instruction, 2: random ready.
    task automatic run_req(input int rd, input logic [31:0] val, input int mode);
        int          budget;
        int          stall;
        logic        rdy;
        logic [31:0] junk;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check_eq("req_ready_before", {31'd0, req_ready}, 32'd1);
        model_push(rd, val);
        req_valid  = 1'b1;
        junk       = rd;
        req_rd     = junk[4:0];
        req_value  = val;
        inst_ready = (mode == 0);
        @(negedge clk);
        stall  = 0;
        budget = 0;
        while (exp_inst_q.size() > 0 && budget < 60) begin
            check_eq("inst_valid", {31'd0, inst_valid}, 32'd1);
            check_eq("inst_out", inst_out, exp_inst_q[0]);
            check_eq("inst_last", {31'd0, inst_last}, {31'd0, exp_last_q[0]});
            check_eq("busy", {31'd0, busy}, 32'd1);
            check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
            check_eq("emit_cnt_run", {16'd0, emit_cnt}, {16'd0, cnt_exp});
            // Requests offered while busy must be ignored.
            junk      = $urandom;
            req_valid = junk[0];
            req_rd    = junk[5:1];
            req_value = $urandom;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (stall == 3);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            inst_ready = rdy;
            if (rdy) begin
                void'(exp_inst_q.pop_front());
                void'(exp_last_q.pop_front());
                cnt_exp = cnt_exp + 16'd1;
                stall   = 0;
            end else begin
                stall++;
            end
            @(negedge clk);
            budget++;
        end
        check_eq("seq_complete", exp_inst_q.size(), 32'd0);
        exp_inst_q.delete();
        exp_last_q.delete();
        req_valid  = 1'b0;
        inst_ready = 1'b0;
        check_eq("inst_valid_after", {31'd0, inst_valid}, 32'd0);
        check_eq("busy_after", {31'd0, busy}, 32'd0);
        check_eq("req_ready_after", {31'd0, req_ready}, 32'd1);
        check_eq("emit_cnt_after", {16'd0, emit_cnt}, {16'd0, cnt_exp});
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return r;
            1:       return r & 32'hFFFF_F000;
            2:       return r & 32'h0000_0FFF;
            3:       return r | 32'hFFFF_F000;
            default: return (r & 32'hFFFF_F000) | 32'h0000_0800;
        endcase
    endfunction

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cnt_exp    = 16'd0;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_rd     = 5'd0;
        req_value  = 32'd0;
        inst_ready = 1'b0;

        // Reset values while rst_n is held low.
        #1 rst_n = 1'b0;
        #3;
        check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst_last", {31'd0, inst_last}, 32'd0);
        check_eq("rst_inst_out", inst_out, 32'd0);
        check_eq("rst_emit_cnt", {16'd0, emit_cnt}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with an always-ready consumer.
        run_req(5, 32'h1234_5FFF, 0);
        run_req(1, 32'hFFFF_F800, 0);
        run_req(1, 32'h0000_07FF, 0);
        run_req(2, 32'h0000_1000, 0);
        run_req(3, 32'h0000_0000, 0);
        run_req(0, $urandom, 0);
        run_req(31, 32'hFFFF_FFFF, 0);
        run_req(7, 32'h8000_0000, 0);

        // Backpressure: 3 stall cycles per instruction.
        run_req(5, 32'h1234_5FFF, 1);

        // Randomized requests and backpressure.
        for (int i = 0; i < 300; i++) begin
            run_req($urandom_range(0, 31), rand_value(), 2);
        end

        // Counter wrap: preload close to the top, then two handshakes.
        force dut.emit_cnt_r = 16'hFFFE;
        @(negedge clk);
        release dut.emit_cnt_r;
        cnt_exp = 16'hFFFE;
        run_req(5, 32'h1234_5FFF, 0);
        check_eq("emit_cnt_wrap", {16'd0, emit_cnt}, 32'd0);

        // Reset while the LUI of a two-instruction sequence is stalled.
        req_valid  = 1'b1;
        req_rd     = 5'd5;
        req_value  = 32'h1234_5FFF;
        inst_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("abort_lui_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("abort_lui_out", inst_out, 32'h1234_62B7);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("abort_rst_out", inst_out, 32'd0);
        check_eq("abort_rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        cnt_exp    = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_post_valid", {31'd0, inst_valid}, 32'd0);
            check_eq("abort_post_busy", {31'd0, busy}, 32'd0);
            check_eq("abort_post_ready", {31'd0, req_ready}, 32'd1);
            check_eq("abort_post_cnt", {16'd0, emit_cnt}, 32'd0);
        end
        inst_ready = 1'b0;

        // Block still works normally after the abort.
        run_req(9, 32'hDEAD_BEEF, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/li_seq_gen.md
LI_SEQ_GEN -- requirements
Module: li_seq_gen

Purpose: expands a "load 32-bit constant into rd" request into the minimal RV32I LUI/ADDI instruction sequence, emitted over a valid/ready stream.

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when high with req_valid.
REQ-006 req_rd  input  5  destination register index.
REQ-007 req_value  input  32  constant to materialise.
REQ-008 inst_valid  output  1  inst_out holds a valid instruction.
REQ-009 inst_ready  input  1  downstream consumes inst_out when high with inst_valid.
REQ-010 inst_out  output  32  encoded RV32I instruction.
REQ-011 inst_last  output  1  inst_out is the final instruction of the current request.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 emit_cnt  output  16  count of completed instruction handshakes.

Function
REQ-014 States SHALL be IDLE, EMIT_LUI, EMIT_ADDI; req_ready SHALL equal (state == IDLE).
REQ-015 On acceptance the block SHALL register rd, hi = (req_value + 32'h800) >> 12 (32-bit add, carry out discarded) and lo = req_value[11:0].
REQ-016 Decision at acceptance: rd == 0 -> EMIT_ADDI with NOP 0x00000013; else hi != 0 -> EMIT_LUI; else EMIT_ADDI with rs1 = x0.
REQ-017 LUI encoding SHALL be {hi[19:0], rd, 7'b0110111}.
REQ-018 ADDI encoding SHALL be {lo, rs1, 3'b000, rd, 7'b0010011}; rs1 = rd when preceded by LUI, x0 otherwise.
REQ-019 The ADDI after a LUI SHALL be omitted when lo == 0; the LUI is then marked inst_last.
REQ-020 inst_valid SHALL rise in the cycle after the accepting edge (latency 1 cycle); inst_valid, inst_out and inst_last are registered outputs.
REQ-021 While inst_valid && !inst_ready, inst_out and inst_last SHALL remain stable and inst_valid SHALL stay high.
REQ-022 On handshake of a non-last instruction, the next instruction SHALL be presented in the following cycle without a bubble.
REQ-023 On handshake with inst_last, the FSM SHALL go to IDLE and deassert inst_valid; req_ready is high in the next cycle (one bubble between requests).
REQ-024 emit_cnt SHALL increment by 1 per instruction handshake and wrap from 0xFFFF to 0x0000.
REQ-025 Requests with req_valid low, or presented while not IDLE, SHALL have no effect.

Reset
REQ-026 While rst_n is low: state = IDLE, inst_valid = 0, inst_last = 0, inst_out = 0, emit_cnt = 0, busy = 0, req_ready = 1.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence; no remaining instruction is emitted after release.

Verification
REQ-028 rd=5, value 0x12345FFF, inst_ready=1 -> 0x123462B7 (last=0), then 0xFFF28293 (last=1); emit_cnt += 2.
REQ-029 rd=1, value 0xFFFFF800 (hi wraps to 0) -> single 0x80000093, last=1; rd=1, value 0x000007FF -> single 0x7FF00093.
REQ-030 rd=2, value 0x00001000 -> single LUI 0x00001137, last=1; rd=3, value 0 -> single 0x00000193; rd=0, any value -> 0x00000013.
REQ-031 Case REQ-028 with inst_ready held low 3 cycles on each instruction -> inst_out stable, no duplicates, emit_cnt += 2 exactly.
REQ-032 rst_n pulsed low while the LUI of REQ-028 is pending -> inst_valid = 0, emit_cnt = 0, req_ready = 1 after release; no ADDI emitted.
REQ-033 emit_cnt preset to 0xFFFF via 65535 handshakes, one more handshake -> emit_cnt = 0x0000.
